// File: rtl/led_cube_scanner.sv
// Frame-buffered, layer-multiplexed driver for an N x N x N RGB LED cube.
// The host writes voxels into an internal buffer. The scanner lights one z-layer at a time from a shadow copy.
module led_cube_scanner #(
  parameter int N     = 8,
  parameter int AW    = 3,
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_x,
  input  logic [AW-1:0]   wr_y,
  input  logic [AW-1:0]   wr_z,
  input  logic [2:0]      wr_color,
  input  logic            clr,
  output logic            busy,
  output logic [N-1:0]    layer_sel,
  output logic [N*N-1:0]  col_r,
  output logic [N*N-1:0]  col_g,
  output logic [N*N-1:0]  col_b,
  output logic [AW-1:0]   layer,
  output logic            frame_tick
);

  localparam int NN   = N * N;
  localparam int NNN  = NN * N;
  localparam int ADW  = $clog2(NNN);
  localparam int IW   = $clog2(NN);
  localparam int MAXC = (NN > DWELL) ? ((NN > BLANK) ? NN : BLANK)
                                     : ((DWELL > BLANK) ? DWELL : BLANK);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0]  LOAD_LAST  = CW'(NN - 1);
  localparam logic [CW-1:0]  SHOW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK - 1);
  localparam logic [AW-1:0]  LAST_LAYER = AW'(N - 1);
  localparam logic [ADW-1:0] CLR_LAST   = ADW'(NNN - 1);
  localparam logic [N-1:0]   SEL_ONE    = N'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [AW-1:0]   layer_nxt;
  logic            tick_nxt;
  logic [NN-1:0]   sh_r, sh_g, sh_b;
  logic [NN-1:0]   sh_r_nxt, sh_g_nxt, sh_b_nxt;
  logic [IW-1:0]   ld_idx;
  logic [2:0]      rd_data;

  logic [2:0]      fb [NNN];
  logic [ADW-1:0]  wr_addr, rd_addr, clr_addr;
  logic            wr_ok;

  always_comb begin
    wr_ok   = wr_en && !busy && (int'(wr_x) < N) && (int'(wr_y) < N) && (int'(wr_z) < N);
    wr_addr = ADW'(int'(wr_z) * NN + int'(wr_y) * N + int'(wr_x));
    rd_addr = ADW'(int'(layer) * NN + int'(cnt));
  end

  // Single write port: the clear sweep owns it while busy, so host writes are dropped then.
  always_ff @(posedge clk) begin
    if (busy)
      fb[clr_addr] <= 3'b000;
    else if (wr_ok)
      fb[wr_addr] <= wr_color;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy     <= 1'b0;
      clr_addr <= '0;
    end else if (busy) begin
      if (clr_addr == CLR_LAST)
        busy <= 1'b0;
      clr_addr <= clr_addr + 1'b1;
    end else if (clr) begin
      busy     <= 1'b1;
      clr_addr <= '0;
    end
  end

  // The buffer read is combinational, so a same-cycle write lands after the shadow has sampled the old value.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    layer_nxt = layer;
    tick_nxt  = 1'b0;
    sh_r_nxt  = sh_r;
    sh_g_nxt  = sh_g;
    sh_b_nxt  = sh_b;
    ld_idx    = IW'(cnt);
    rd_data   = fb[rd_addr];
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      layer_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
          layer_nxt = '0;
        end
        S_LOAD: begin
          sh_r_nxt[ld_idx] = rd_data[2];
          sh_g_nxt[ld_idx] = rd_data[1];
          sh_b_nxt[ld_idx] = rd_data[0];
          if (cnt == LOAD_LAST) begin
            state_nxt = S_SHOW;
            cnt_nxt   = '0;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
            layer_nxt = (layer == LAST_LAYER) ? '0 : layer + 1'b1;
            tick_nxt  = (layer == LAST_LAYER);
          end
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = S_LOAD;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          layer_nxt = '0;
        end
      endcase
    end
  end

  // Drive outputs from the next state so the pins change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      layer      <= '0;
      frame_tick <= 1'b0;
      sh_r       <= '0;
      sh_g       <= '0;
      sh_b       <= '0;
      layer_sel  <= '0;
      col_r      <= '1;
      col_g      <= '1;
      col_b      <= '1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      layer      <= layer_nxt;
      frame_tick <= tick_nxt;
      sh_r       <= sh_r_nxt;
      sh_g       <= sh_g_nxt;
      sh_b       <= sh_b_nxt;
      if (state_nxt == S_SHOW) begin
        layer_sel <= SEL_ONE << layer_nxt;
        col_r     <= ~sh_r_nxt;
        col_g     <= ~sh_g_nxt;
        col_b     <= ~sh_b_nxt;
      end else begin
        layer_sel <= '0;
        col_r     <= '1;
        col_g     <= '1;
        col_b     <= '1;
      end
    end
  end

endmodule

// File: tb/tb_led_cube_scanner.sv
// Self-checking bench for led_cube_scanner (N=4, DWELL=8, BLANK=2).
// A frame-buffer model feeds a scoreboard of expected SHOW windows.
module tb_led_cube_scanner;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  typedef struct packed {
    logic [3:0]  sel;
    logic [1:0]  lyr;
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } show_t;

  logic        clk = 1'b0;
  logic        resetn, enable, wr_en, clr, busy, frame_tick;
  logic [1:0]  wr_x, wr_y, wr_z, layer;
  logic [2:0]  wr_color;
  logic [3:0]  layer_sel;
  logic [15:0] col_r, col_g, col_b;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  model_fb [64];
  show_t       sb [$];

  led_cube_scanner #(.N(N), .AW(AW), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_color(wr_color), .clr(clr),
    .busy(busy), .layer_sel(layer_sel), .col_r(col_r), .col_g(col_g),
    .col_b(col_b), .layer(layer), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic show_t exp_show(input int z);
    show_t s;
    s.sel = 4'(1 << z);
    s.lyr = 2'(z);
    s.r = '1; s.g = '1; s.b = '1;
    for (int i = 0; i < 16; i++) begin
      s.r[i] = ~model_fb[z*16+i][2];
      s.g[i] = ~model_fb[z*16+i][1];
      s.b[i] = ~model_fb[z*16+i][0];
    end
    return s;
  endfunction

  // Captures the next complete SHOW window and how many cycles it held steady.
  task automatic next_show(output show_t s, output int len, output bit ok);
    int n;
    s = '0; len = 0; ok = 1'b0;
    n = 0;
    while (layer_sel !== 4'b0000 && n < 100) begin tick(); n++; end
    n = 0;
    while (layer_sel === 4'b0000 && n < 200) begin tick(); n++; end
    if (layer_sel === 4'b0000) return;
    ok = 1'b1;
    s.sel = layer_sel; s.lyr = layer; s.r = col_r; s.g = col_g; s.b = col_b;
    while (len < 100 && layer_sel === s.sel && layer === s.lyr &&
           col_r === s.r && col_g === s.g && col_b === s.b) begin
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; wr_en = 1'b0; clr = 1'b0;
    wr_x = '0; wr_y = '0; wr_z = '0; wr_color = '0;
    repeat (3) tick();
    checks++; if (layer_sel !== 4'b0000) begin errors++; $display("[TB] FAIL reset_layer_sel got %b exp 0000", layer_sel); end
    checks++; if (col_r !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_col_r got %h exp ffff", col_r); end
    checks++; if (col_g !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_col_g got %h exp ffff", col_g); end
    checks++; if (col_b !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_col_b got %h exp ffff", col_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_tick got %b exp 0", frame_tick); end
    checks++; if (layer !== 2'd0) begin errors++; $display("[TB] FAIL reset_layer got %0d exp 0", layer); end
    resetn = 1'b1;
  endtask

  task automatic test_single_voxel();
    int nb;
    show_t got, exp;
    int len;
    bit ok;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 64; i++) model_fb[i] = 3'b000;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin nb++; tick(); end
    checks++; if (nb !== 64) begin errors++; $display("[TB] FAIL clear_busy_len got %0d exp 64", nb); end
    wr_en = 1'b1; wr_x = 2'd1; wr_y = 2'd2; wr_z = 2'd3; wr_color = 3'b101;
    tick();
    wr_en = 1'b0;
    model_fb[3*16 + 2*4 + 1] = 3'b101;
    for (int z = 0; z < 4; z++) sb.push_back(exp_show(z));
    enable = 1'b1;
    repeat (4) begin
      next_show(got, len, ok);
      exp = sb.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("[TB] FAIL voxel_show got %h exp %h", got, exp); end
      checks++; if (len !== DWELL) begin errors++; $display("[TB] FAIL voxel_dwell got %0d exp %0d", len, DWELL); end
    end
  endtask

  task automatic test_frame_tick();
    int ticks [$];
    logic [3:0] prev_sel;
    prev_sel = layer_sel;
    for (int c = 0; c < 320; c++) begin
      tick();
      if (frame_tick === 1'b1) begin
        ticks.push_back(c);
        checks++;
        if (prev_sel !== 4'b1000 || layer_sel !== 4'b0000) begin
          errors++; $display("[TB] FAIL tick_position prev_sel %b sel %b exp 1000/0000", prev_sel, layer_sel);
        end
      end
      prev_sel = layer_sel;
    end
    checks++; if (ticks.size() !== 3) begin errors++; $display("[TB] FAIL tick_count got %0d exp 3", ticks.size()); end
    for (int i = 1; i < ticks.size(); i++) begin
      checks++;
      if (ticks[i] - ticks[i-1] !== 104) begin
        errors++; $display("[TB] FAIL tick_period got %0d exp 104", ticks[i] - ticks[i-1]);
      end
    end
  endtask

  task automatic test_clear_drops_write();
    int nb, n;
    show_t got, exp;
    int len;
    bit ok;
    wr_x = 2'd0; wr_y = 2'd0; wr_z = 2'd0; wr_color = 3'b111;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 64; i++) model_fb[i] = 3'b000;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_busy_rise got %b exp 1", busy); end
    nb = 1;
    for (int k = 1; k <= 100; k++) begin
      wr_en = (k == 5);
      tick();
      if (busy === 1'b1) nb++;
      else break;
    end
    wr_en = 1'b0;
    checks++; if (nb !== 64) begin errors++; $display("[TB] FAIL clr_busy_len got %0d exp 64", nb); end
    n = 0;
    while (frame_tick !== 1'b1 && n < 150) begin tick(); n++; end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL clr_frame_wait got %b exp 1", frame_tick); end
    for (int z = 0; z < 4; z++) sb.push_back(exp_show(z));
    repeat (4) begin
      next_show(got, len, ok);
      exp = sb.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("[TB] FAIL clr_show got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_enable_toggle();
    int n;
    n = 0;
    while (layer_sel !== 4'b0100 && n < 200) begin tick(); n++; end
    checks++; if (layer_sel !== 4'b0100) begin errors++; $display("[TB] FAIL en_find_layer2 got %b exp 0100", layer_sel); end
    enable = 1'b0;
    tick();
    checks++; if (layer_sel !== 4'b0000) begin errors++; $display("[TB] FAIL en_off_sel got %b exp 0000", layer_sel); end
    checks++;
    if ({col_r, col_g, col_b} !== 48'hFFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL en_off_cols got %h %h %h exp ffff", col_r, col_g, col_b);
    end
    checks++; if (layer !== 2'd0) begin errors++; $display("[TB] FAIL en_off_layer got %0d exp 0", layer); end
    repeat (3) tick();
    checks++; if (layer_sel !== 4'b0000) begin errors++; $display("[TB] FAIL en_idle_sel got %b exp 0000", layer_sel); end
    enable = 1'b1;
    n = 0;
    while (n < 100) begin
      tick(); n++;
      if (layer_sel !== 4'b0000) break;
    end
    checks++; if (n !== 17) begin errors++; $display("[TB] FAIL en_restart_delay got %0d exp 17", n); end
    checks++; if (layer_sel !== 4'b0001 || layer !== 2'd0) begin
      errors++; $display("[TB] FAIL en_restart_layer got %b/%0d exp 0001/0", layer_sel, layer);
    end
  endtask

  task automatic test_shadow_and_reset();
    int n;
    show_t cur, got, exp;
    int len;
    bit ok;
    n = 0;
    while (layer_sel !== 4'b0010 && n < 200) begin tick(); n++; end
    cur = exp_show(1);
    wr_en = 1'b1; wr_x = 2'd2; wr_y = 2'd1; wr_z = 2'd1; wr_color = 3'b010;
    tick();
    wr_en = 1'b0;
    model_fb[1*16 + 1*4 + 2] = 3'b010;
    n = 0;
    while (layer_sel === 4'b0010 && n < 20) begin
      got.sel = layer_sel; got.lyr = layer; got.r = col_r; got.g = col_g; got.b = col_b;
      checks++; if (got !== cur) begin errors++; $display("[TB] FAIL shadow_hold got %h exp %h", got, cur); end
      tick(); n++;
    end
    checks++; if (n !== DWELL - 1) begin errors++; $display("[TB] FAIL shadow_hold_len got %0d exp %0d", n, DWELL - 1); end
    sb.push_back(exp_show(2));
    sb.push_back(exp_show(3));
    sb.push_back(exp_show(0));
    sb.push_back(exp_show(1));
    repeat (4) begin
      next_show(got, len, ok);
      exp = sb.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("[TB] FAIL shadow_show got %h exp %h", got, exp); end
    end
    n = 0;
    while (layer_sel === 4'b0000 && n < 100) begin tick(); n++; end
    resetn = 1'b0;
    tick();
    checks++; if (layer_sel !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_sel got %b exp 0000", layer_sel); end
    checks++;
    if ({col_r, col_g, col_b} !== 48'hFFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL midreset_cols got %h %h %h exp ffff", col_r, col_g, col_b);
    end
    checks++; if ({busy, frame_tick, layer} !== 4'b0000) begin
      errors++; $display("[TB] FAIL midreset_misc got %b exp 0000", {busy, frame_tick, layer});
    end
    resetn = 1'b1;
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_voxel();
    test_frame_tick();
    test_clear_drops_write();
    test_enable_toggle();
    test_shadow_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
